// File: rtl/mem_block_reader_pkg.sv
// Shared constants and the state type for the data-memory block reader.
package mem_block_reader_pkg;

  // Data-memory geometry and the output-register window.
  localparam int DATA_ADDR_WIDTH = 8;
  localparam int OUT_MEM         = 'hF0;
  localparam int OUT_NUM         = 8;
  localparam int OUT_NUM_WIDTH   = 3;

  // Transfer sequencer states (2-bit register).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/mem_block_reader.sv
// DMA reader: copies WORD_COUNT consecutive 16-bit words from data memory
// starting at BASE_ADDR into a shadow buffer, then commits the whole buffer
// to words_out at a single clock edge so consumers never see a partial set.
// The data-memory read port is only driven (mem_rd_en) while in FETCH.
module mem_block_reader
  import mem_block_reader_pkg::*;
#(
  parameter int WORD_COUNT       = OUT_NUM,
  parameter int ADDR_WIDTH       = DATA_ADDR_WIDTH,
  parameter int BASE_ADDR        = OUT_MEM,
  parameter int WORD_COUNT_WIDTH = OUT_NUM_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     copy_start,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [15:0]              mem_din,
  output logic                     busy,
  output logic                     copy_done,
  output logic [WORD_COUNT*16-1:0] words_out,
  output logic [1:0]               state_dbg
);

  localparam logic [ADDR_WIDTH-1:0]       BASE_A   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [WORD_COUNT_WIDTH-1:0] LAST_IDX = WORD_COUNT_WIDTH'(WORD_COUNT - 1);

  state_t                      state;
  logic [WORD_COUNT_WIDTH-1:0] index;
  logic                        cap_valid;
  logic [WORD_COUNT_WIDTH-1:0] cap_idx;
  logic [15:0]                 shadow [WORD_COUNT];

  assign state_dbg = state;

  // Transfer sequencer; read strobe, address, busy and copy_done are
  // registered so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      index       <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= BASE_A;
      busy        <= 1'b0;
      copy_done   <= 1'b0;
    end else begin
      copy_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (copy_start) begin
            state       <= ST_FETCH;
            index       <= '0;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= BASE_A;
            busy        <= 1'b1;
          end
        end
        ST_FETCH: begin
          index <= index + 1'b1;
          if (index == LAST_IDX) begin
            state       <= ST_FLUSH;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= BASE_A;
          end else begin
            // Address arithmetic wraps modulo 2**ADDR_WIDTH.
            mem_rd_addr <= BASE_A + ADDR_WIDTH'(index + 1'b1);
          end
        end
        ST_FLUSH: begin
          state     <= ST_COMMIT;
          copy_done <= 1'b1;
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          mem_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Capture pipeline: each issued read lands in the shadow buffer one
  // cycle later, when the synchronous RAM presents its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_idx   <= '0;
      for (int i = 0; i < WORD_COUNT; i++) begin
        shadow[i] <= 16'h0000;
      end
    end else begin
      cap_valid <= (state == ST_FETCH);
      cap_idx   <= index;
      if (cap_valid) begin
        shadow[cap_idx] <= mem_din;
      end
    end
  end

  // Atomic commit: every word of words_out is replaced at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_out <= '0;
    end else if (state == ST_COMMIT) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        words_out[16*i +: 16] <= shadow[i];
      end
    end
  end

endmodule
